// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb sequencer and the password block it drives.
package bomb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_DEFUSED   = 3'd2,
      ST_DETONATED = 3'd3,
      ST_CLEAR     = 3'd4
   } state_t;

   // Password block mode input.
   localparam logic MODE_PROGRAMMING = 1'b0;
   localparam logic MODE_UNLOCKING   = 1'b1;

   // Programmed-key counter saturates here.
   localparam logic [3:0] PROG_COUNT_MAX = 4'd8;

   // Keep only the lowest set bit, so simultaneous keys resolve to the lowest index.
   function automatic logic [2:0] lowest_one(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

endpackage

// File: rtl/bomb_sequencer_key_debouncer.sv
// One button input: 2-flop synchronizer, stable-level debouncer and a
// registered single-cycle pulse on each accepted rising edge.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   // Count consecutive samples that disagree with the stable level; flip after DEBOUNCE_CYCLES.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      pulse_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            pulse_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer, debounce state and pulse register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/bomb_sequencer.sv
// Bomb game sequencer: conditions buttons into key strobes, drives the password
// block's mode/clear and runs arm / countdown / defuse / detonate.
module bomb_sequencer
   import bomb_pkg::*;
#(
   parameter int TICKS_PER_SEC   = 50000000,
   parameter int COUNTDOWN_SEC   = 60,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       async_reset,
   input  logic [2:0] key_raw,
   input  logic       arm_raw,
   input  logic       pw_unlocked,
   input  logic       pw_explode,
   output logic [2:0] key_pulse,
   output logic       pw_mode,
   output logic       pw_clear,
   output logic [2:0] state,
   output logic [7:0] seconds_left,
   output logic       defused,
   output logic       detonate
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   logic [2:0]    key_rdy;
   logic          arm_rdy;
   logic [2:0]    key_win;
   logic          tick;

   state_t        state_q, state_d;
   logic [7:0]    secs_q, secs_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    prog_count_q, prog_count_d;
   logic [2:0]    key_q, key_d;
   logic          mode_q, mode_d;
   logic          clear_q, clear_d;
   logic          defused_q, defused_d;
   logic          detonate_q, detonate_d;

   for (genvar g = 0; g < 3; g++) begin : g_key
      key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clk_i   (clk),
         .rst_i   (async_reset),
         .raw_i   (key_raw[g]),
         .pulse_o (key_rdy[g])
      );
   end

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm (
      .clk_i   (clk),
      .rst_i   (async_reset),
      .raw_i   (arm_raw),
      .pulse_o (arm_rdy)
   );

   assign key_win = lowest_one(key_rdy);
   assign tick    = (presc_q == PW'(TICKS_PER_SEC - 1));

   // Next state, countdown, key gating and registered-output values.
   always_comb begin
      state_d      = state_q;
      secs_d       = secs_q;
      presc_d      = presc_q;
      prog_count_d = prog_count_q;
      key_d        = '0;
      unique case (state_q)
         ST_IDLE: begin
            key_d = key_win;
            if (key_win != 3'b000 && prog_count_q != PROG_COUNT_MAX)
               prog_count_d = prog_count_q + 4'd1;
            if (arm_rdy && prog_count_q != 4'd0) begin
               state_d = ST_ARMED;
               secs_d  = 8'(COUNTDOWN_SEC);
               presc_d = '0;
            end
         end
         ST_ARMED: begin
            key_d   = key_win;
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (pw_unlocked) begin
               state_d = ST_DEFUSED;
            end else if (pw_explode) begin
               state_d = ST_DETONATED;
            end else if (tick) begin
               if (secs_q <= 8'd1) begin
                  secs_d  = 8'd0;
                  state_d = ST_DETONATED;
               end else begin
                  secs_d = secs_q - 8'd1;
               end
            end
         end
         ST_DEFUSED, ST_DETONATED: begin
            if (arm_rdy) begin
               state_d      = ST_CLEAR;
               secs_d       = 8'd0;
               prog_count_d = 4'd0;
            end
         end
         ST_CLEAR: begin
            state_d      = ST_IDLE;
            secs_d       = 8'd0;
            prog_count_d = 4'd0;
         end
         default: state_d = ST_IDLE;
      endcase
      mode_d     = (state_d == ST_ARMED || state_d == ST_DEFUSED || state_d == ST_DETONATED)
                   ? MODE_UNLOCKING : MODE_PROGRAMMING;
      clear_d    = (state_d == ST_CLEAR);
      defused_d  = (state_d == ST_DEFUSED);
      detonate_d = (state_d == ST_DETONATED);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state_q      <= ST_IDLE;
         secs_q       <= 8'd0;
         presc_q      <= '0;
         prog_count_q <= 4'd0;
         key_q        <= 3'b000;
         mode_q       <= MODE_PROGRAMMING;
         clear_q      <= 1'b0;
         defused_q    <= 1'b0;
         detonate_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         secs_q       <= secs_d;
         presc_q      <= presc_d;
         prog_count_q <= prog_count_d;
         key_q        <= key_d;
         mode_q       <= mode_d;
         clear_q      <= clear_d;
         defused_q    <= defused_d;
         detonate_q   <= detonate_d;
      end
   end

   assign key_pulse    = key_q;
   assign pw_mode      = mode_q;
   assign pw_clear     = clear_q;
   assign state        = state_q;
   assign seconds_left = secs_q;
   assign defused      = defused_q;
   assign detonate     = detonate_q;

endmodule
